// File: rtl/operand_forward_unit.sv
// Operand bypass for EXE: youngest matching producer wins, load-use hazards stall ID.
// Latency: 1 cycle from ID accept to src_valid; stall/id_ready are combinational.
// Backpressure: id_ready drops on a hazard or while a held operand set is not consumed.
module operand_forward_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_addr,
    input  logic [NUM_SRC*DATA_W-1:0] rs_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    output logic                      src_valid,
    input  logic                      src_ready,
    output logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      stall,
    input  logic                      perf_clr,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          stall_events
);

    typedef enum logic {RUN, STALL} state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        stall_evt;
    logic [NUM_SRC-1:0]          hazard;
    logic [NUM_SRC*DATA_W-1:0]   sel_dat;
    logic [NUM_SRC-1:0]          found;
    logic                        any_hazard;
    logic                        capture;

    // Scan stages youngest-first; once a stage wins, older matches are ignored.
    always_comb begin
        hazard  = '0;
        found   = '0;
        sel_dat = rs_data;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!found[i] && fwd_valid[k]
                    && (fwd_rd[k*ADDR_W +: ADDR_W] == rs_addr[i*ADDR_W +: ADDR_W])
                    && (rs_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                    found[i] = 1'b1;
                    if (fwd_pending[k]) begin
                        hazard[i] = 1'b1;
                    end else begin
                        sel_dat[i*DATA_W +: DATA_W] = fwd_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign any_hazard = |hazard;
    assign stall      = id_valid && any_hazard;
    assign id_ready   = !any_hazard && (!src_valid || src_ready);
    assign capture    = id_valid && id_ready;

    always_comb begin
        state_d   = state_q;
        stall_evt = 1'b0;
        case (state_q)
            RUN: begin
                if (stall) begin
                    state_d   = STALL;
                    stall_evt = 1'b1;
                end
            end
            STALL: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A capture overrides a same-cycle consume so back-to-back operands flow without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_valid <= 1'b0;
            src_data  <= '0;
        end else if (capture) begin
            src_valid <= 1'b1;
            src_data  <= sel_dat;
        end else if (src_ready) begin
            src_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles <= '0;
            stall_events <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (stall_evt && (stall_events != '1)) begin
                stall_events <= stall_events + CNT_W'(1);
            end
        end
    end

endmodule
